// File: rtl/inv_cipher_ctrl_if.sv
// Request and round-datapath signals between the AES inverse-cipher sequencer and its surroundings.
// The abort line exists only when INV_CTRL_ABORT_EN is defined.
interface inv_cipher_ctrl_if;
  logic         start;
  logic [127:0] ciphertext;
  logic [3:0]   key_idx;
  logic [127:0] round_key;
  logic [127:0] rnd_in;
  logic [127:0] rnd_out;
  logic [127:0] lst_out;
  logic         busy;
  logic         done;
  logic [127:0] plaintext;
`ifdef INV_CTRL_ABORT_EN
  logic         abort;
`endif

  modport master (
    output start, ciphertext, round_key, rnd_out, lst_out,
`ifdef INV_CTRL_ABORT_EN
    output abort,
`endif
    input  key_idx, rnd_in, busy, done, plaintext
  );

  modport slave (
    input  start, ciphertext, round_key, rnd_out, lst_out,
`ifdef INV_CTRL_ABORT_EN
    input  abort,
`endif
    output key_idx, rnd_in, busy, done, plaintext
  );
endinterface

// File: rtl/inv_cipher_ctrl.sv
// Iterative AES inverse-cipher sequencer: state register, round counter, key index and handshake.
// Optional abort input is compiled in with INV_CTRL_ABORT_EN.
module inv_cipher_ctrl #(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  inv_cipher_ctrl_if.slave bus
);
  if (Nr != Nk + 6) begin : g_cfg_check
    $error("inv_cipher_ctrl: Nr must equal Nk+6");
  end

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_ROUND = 3'd2;
  localparam logic [2:0] S_FINAL = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [3:0] NR_IDX   = 4'(Nr);
  localparam logic [3:0] CNT_INIT = 4'(Nr - 1);

  logic [2:0]   st;
  logic [127:0] state_q;
  logic [127:0] pt_q;
  logic [3:0]   cnt;
  logic         busy_w;
  logic         abort_hit;

  assign busy_w = (st == S_INIT) || (st == S_ROUND) || (st == S_FINAL);

`ifdef INV_CTRL_ABORT_EN
  assign abort_hit = bus.abort & busy_w;
`else
  assign abort_hit = 1'b0;
`endif

  // Key index decodes registered state only, so it is stable for the whole cycle.
  always_comb begin
    bus.key_idx = 4'd0;
    case (st)
      S_INIT:  bus.key_idx = NR_IDX;
      S_ROUND: bus.key_idx = cnt;
      default: bus.key_idx = 4'd0;
    endcase
  end

  assign bus.rnd_in    = state_q;
  assign bus.busy      = busy_w;
  assign bus.done      = (st == S_DONE);
  assign bus.plaintext = pt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= S_IDLE;
      state_q <= '0;
      pt_q    <= '0;
      cnt     <= '0;
    end else if (abort_hit) begin
      st <= S_IDLE;
    end else begin
      case (st)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state_q <= bus.ciphertext;
            st      <= S_INIT;
          end else begin
            st <= S_IDLE;
          end
        end
        S_INIT: begin
          state_q <= state_q ^ bus.round_key;
          cnt     <= CNT_INIT;
          st      <= S_ROUND;
        end
        S_ROUND: begin
          state_q <= bus.rnd_out;
          cnt     <= cnt - 4'd1;
          // Leaving at 1 keeps the counter from ever wrapping.
          if (cnt == 4'd1) st <= S_FINAL;
        end
        S_FINAL: begin
          pt_q    <= bus.lst_out;
          state_q <= bus.lst_out;
          st      <= S_DONE;
        end
        default: st <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/inv_cipher_ctrl.md
Name: inv_cipher_ctrl

Overview:
- Iterative AES inverse-cipher sequencer. Owns the 128-bit state register, round counter and handshake.
- Drives one shared external full inverse round unit and one external last-round unit (no InvMixColumns) once per cycle.
- Supplies round-key indices to an external key store, counting down from Nr to 0.
- Sits between the decrypt request interface and the combinational round datapath.

Parameters:
- Nk, 4, key length in 32-bit words (4/6/8).
- Nr, 10, number of rounds (10/12/14); must equal Nk+6.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; one clock, reset is asynchronous and active-low.
- start  input  1  request pulse; sampled when not busy.
- ciphertext  input  128  block, latched on accepted start.
- key_idx  output  4  round-key index requested from key store.
- round_key  input  128  key for key_idx, valid combinationally in the same cycle.
- rnd_in  output  128  state fed to both round units; equals the state register.
- rnd_out  input  128  full inverse round result for rnd_in/round_key.
- lst_out  input  128  last-round result for rnd_in/round_key.
- busy  output  1  high in INIT, ROUND and FINAL.
- done  output  1  one-cycle completion pulse.
- plaintext  output  128  result register; held until overwritten.

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE, state register=0, counter=0, key_idx=0, busy=0, done=0, plaintext=0. Mid-operation reset aborts immediately; no done.
- FSM states: IDLE, INIT, ROUND, FINAL, DONE.
- IDLE/DONE: key_idx=0. start=1 at an edge latches ciphertext into the state register and moves to INIT. Otherwise the FSM goes to or stays in IDLE.
- INIT: key_idx=Nr. On the edge: state <= rnd_in ^ round_key, counter <= Nr-1, go to ROUND.
- ROUND: key_idx=counter. On each edge: state <= rnd_out and counter decrements. If counter==1 at the edge, go to FINAL; otherwise stay in ROUND. ROUND lasts Nr-1 cycles.
- FINAL: key_idx=0. On the edge: plaintext <= lst_out and state <= lst_out; go to DONE.
- DONE: done=1 for exactly this cycle. start is accepted here exactly as in IDLE, allowing back-to-back blocks.
- Latency: start sampled at edge k gives done high in the cycle after edge k+Nr+1. For Nr=10, done is high in the 12th cycle after start.
- Throughput: one block per Nr+2 cycles.
- start while busy=1: ignored. The in-flight operation and ciphertext latch are unaffected.
- busy and done are never high together. plaintext changes only at the FINAL edge or at reset.
- key_idx is a registered-state decode: glitch-free and stable for the whole cycle.
- Counter width 4 bits; it never wraps because FINAL is entered at counter==1.

Optional Feature:
- INV_CTRL_ABORT_EN defined: adds input port abort (1 bit).
  - abort=1 at an edge in INIT/ROUND/FINAL: go to IDLE, busy=0, no done, plaintext unchanged.
  - abort has priority over FINAL completion in the same cycle.
  - abort in IDLE/DONE: no effect; start in the same cycle is still accepted.
- Not defined: port absent; operations always run to completion.

Test Plan:
- Bench setup: real InvRound, real last-round unit and the AES-128 key ROM for key 000102030405060708090a0b0c0d0e0f.
- FIPS-197 C.1: ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a -> plaintext 00112233445566778899aabbccddeeff; done exactly 12 cycles after start; busy high for 11 cycles.
- key_idx trace, same run: 10,9,8,...,1,0 on consecutive busy cycles, then 0 in IDLE/DONE.
- start pulsed again mid-operation, cycle 5 -> ignored; identical result and timing, single done.
- Back-to-back: start held high through DONE with a second ciphertext -> second done 12 cycles after the first; first plaintext stable until the second FINAL edge.
- rst_n pulsed low at ROUND cycle 4 -> all outputs 0 immediately; no done; a fresh start then yields the correct plaintext.
- INV_CTRL_ABORT_EN: abort at the FINAL cycle -> no done; plaintext keeps its prior value; busy=0 next cycle.
